// File: rtl/sketch_painter.sv
// Sketch painter: clears a VRAM on reset/request and paints 4x4 brush blocks
// at touch positions. One VRAM write per enabled clock, registered outputs.
//
// Write port semantics: vram_wr_addr/vram_wr_data are valid whenever
// vram_wr_ena=1; the VRAM has no backpressure, so every strobed cycle is one
// completed write. touch is a level input sampled on enabled clock edges.

package sketch_painter_pkg;
  typedef logic [15:0] ILI9341_color_t;

  typedef struct packed {
    logic       valid;
    logic [8:0] x;
    logic [8:0] y;
  } touch_t;
endpackage

module sketch_painter
  import sketch_painter_pkg::*;
#(
  parameter int             DISPLAY_WIDTH  = 240,
  parameter int             DISPLAY_HEIGHT = 320,
  parameter int             VRAM_L         = DISPLAY_WIDTH * DISPLAY_HEIGHT,
  parameter ILI9341_color_t CLEAR_COLOR    = 16'h0000
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        ena,
  input  touch_t                      touch,
  input  logic                        clear,
  input  ILI9341_color_t              brush_color,
  output logic                        vram_wr_ena,
  output logic [$clog2(VRAM_L)-1:0]   vram_wr_addr,
  output ILI9341_color_t              vram_wr_data,
  output logic                        busy
);

  localparam int             AW     = $clog2(VRAM_L);
  localparam logic [AW-1:0]  W_A    = AW'(DISPLAY_WIDTH);
  localparam logic [AW-1:0]  LAST_A = AW'(VRAM_L - 1);
  localparam logic [9:0]     W_L    = 10'(DISPLAY_WIDTH);
  localparam logic [9:0]     H_L    = 10'(DISPLAY_HEIGHT);

  typedef enum logic [1:0] {
    S_CLEAR = 2'd0,
    S_IDLE  = 2'd1,
    S_PAINT = 2'd2
  } state_t;

  state_t          r_state;
  logic [AW-1:0]   r_sweep;
  logic [1:0]      r_dx;
  logic [1:0]      r_dy;
  logic [8:0]      r_ox;
  logic [8:0]      r_oy;
  ILI9341_color_t  r_color;
  logic            r_pend_clr;
  logic            r_last_vld;
  logic [6:0]      r_last_bx;
  logic [6:0]      r_last_by;
  logic            r_prev_valid;
  logic            r_wr_ena;
  logic [AW-1:0]   r_wr_addr;
  ILI9341_color_t  r_wr_data;

  logic            w_in_range;
  logic            w_same_blk;
  logic            w_rise;
  logic            w_start;
  logic [8:0]      w_bx;
  logic [8:0]      w_by;
  logic            w_brush_last;

  // Linear VRAM address of pixel (ox+dx, oy+dy), row-major
  function automatic logic [AW-1:0] pix_addr(input logic [8:0] ox,
                                             input logic [8:0] oy,
                                             input logic [1:0] dx,
                                             input logic [1:0] dy);
    logic [AW-1:0] row;
    logic [AW-1:0] col;
    row = AW'(oy) + AW'(dy);
    col = AW'(ox) + AW'(dx);
    return row * W_A + col;
  endfunction

  // Brush start decision: in-range touch on a new block, or a fresh press
  assign w_in_range   = ({1'b0, touch.x} < W_L) && ({1'b0, touch.y} < H_L);
  assign w_same_blk   = r_last_vld && (touch.x[8:2] == r_last_bx) &&
                        (touch.y[8:2] == r_last_by);
  assign w_rise       = touch.valid && !r_prev_valid;
  assign w_start      = touch.valid && w_in_range && (w_rise || !w_same_blk);
  assign w_bx         = {touch.x[8:2], 2'b00};
  assign w_by         = {touch.y[8:2], 2'b00};
  assign w_brush_last = (r_dx == 2'd3) && (r_dy == 2'd3);

  // Main FSM: clear sweep, idle touch sampling, 4x4 brush painting
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_CLEAR;
      r_sweep      <= '0;
      r_dx         <= 2'd0;
      r_dy         <= 2'd0;
      r_ox         <= '0;
      r_oy         <= '0;
      r_color      <= '0;
      r_pend_clr   <= 1'b0;
      r_last_vld   <= 1'b0;
      r_last_bx    <= '0;
      r_last_by    <= '0;
      r_prev_valid <= 1'b0;
      r_wr_ena     <= 1'b0;
      r_wr_addr    <= '0;
      r_wr_data    <= '0;
    end else if (ena) begin
      r_prev_valid <= touch.valid;
      r_wr_ena     <= 1'b0;
      case (r_state)
        S_CLEAR: begin
          // Clear requests here are ignored; the sweep stops at the last word
          r_wr_ena  <= 1'b1;
          r_wr_addr <= r_sweep;
          r_wr_data <= CLEAR_COLOR;
          if (r_sweep == LAST_A) begin
            r_state <= S_IDLE;
          end else begin
            r_sweep <= r_sweep + 1'b1;
          end
        end
        S_IDLE: begin
          if (clear) begin
            r_state    <= S_CLEAR;
            r_sweep    <= '0;
            r_last_vld <= 1'b0;
          end else if (w_start) begin
            // First brush pixel goes out on the same edge that accepts the touch
            r_state   <= S_PAINT;
            r_ox      <= w_bx;
            r_oy      <= w_by;
            r_color   <= brush_color;
            r_wr_ena  <= 1'b1;
            r_wr_addr <= pix_addr(w_bx, w_by, 2'd0, 2'd0);
            r_wr_data <= brush_color;
            r_dx      <= 2'd1;
            r_dy      <= 2'd0;
          end
        end
        S_PAINT: begin
          r_wr_ena  <= 1'b1;
          r_wr_addr <= pix_addr(r_ox, r_oy, r_dx, r_dy);
          r_wr_data <= r_color;
          r_dx      <= r_dx + 2'd1;
          if (r_dx == 2'd3) begin
            r_dy <= r_dy + 2'd1;
          end
          if (w_brush_last) begin
            r_pend_clr <= 1'b0;
            if (r_pend_clr || clear) begin
              r_state    <= S_CLEAR;
              r_sweep    <= '0;
              r_last_vld <= 1'b0;
            end else begin
              r_state    <= S_IDLE;
              r_last_vld <= 1'b1;
              r_last_bx  <= r_ox[8:2];
              r_last_by  <= r_oy[8:2];
            end
          end else begin
            r_pend_clr <= r_pend_clr | clear;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end else begin
      r_wr_ena <= 1'b0;
    end
  end

  assign vram_wr_ena  = r_wr_ena;
  assign vram_wr_addr = r_wr_addr;
  assign vram_wr_data = r_wr_data;
  assign busy         = (r_state != S_IDLE);

endmodule

// File: tb/tb_sketch_painter.sv
// Bench for sketch_painter on a reduced 40x24 display. Drivers push the
// expected write stream into a queue from the painting rules; a monitor
// checks every DUT write against the queue front.

module tb_sketch_painter;
  import sketch_painter_pkg::*;

  localparam int W  = 40;
  localparam int H  = 24;
  localparam int VL = W * H;
  localparam int AW = $clog2(VL);
  localparam logic [15:0] CLR = 16'h0000;

  // ---------------- clock / reset / DUT ----------------
  logic           clk = 1'b0;
  logic           rst;
  logic           ena;
  logic           clear;
  touch_t         touch;
  ILI9341_color_t brush_color;
  logic           vram_wr_ena;
  logic [AW-1:0]  vram_wr_addr;
  ILI9341_color_t vram_wr_data;
  logic           busy;

  always #5 clk = ~clk;

  sketch_painter #(
    .DISPLAY_WIDTH (W),
    .DISPLAY_HEIGHT(H),
    .VRAM_L        (VL),
    .CLEAR_COLOR   (CLR)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ena         (ena),
    .touch       (touch),
    .clear       (clear),
    .brush_color (brush_color),
    .vram_wr_ena (vram_wr_ena),
    .vram_wr_addr(vram_wr_addr),
    .vram_wr_data(vram_wr_data),
    .busy        (busy)
  );

  // ---------------- scoreboard ----------------
  logic [AW+15:0] exp_q[$];
  int n_total = 0;
  int n_bad   = 0;
  int wr_count = 0;
  logic [AW-1:0] last_addr = '0;
  logic ena_at_edge = 1'b0;
  bit en_rand = 1'b0;

  // model state: last painted block and last sampled touch.valid
  bit m_last_vld = 1'b0;
  int m_last_bx  = 0;
  int m_last_by  = 0;
  bit m_prev     = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_total++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  function automatic void push_brush(input int bx, input int by, input logic [15:0] c);
    logic [AW-1:0] a;
    for (int dy = 0; dy < 4; dy++) begin
      for (int dx = 0; dx < 4; dx++) begin
        a = AW'((by + dy) * W + bx + dx);
        exp_q.push_back({a, c});
      end
    end
  endfunction

  function automatic void push_clear();
    logic [AW-1:0] a;
    for (int i = 0; i < VL; i++) begin
      a = AW'(i);
      exp_q.push_back({a, CLR});
    end
  endfunction

  always @(posedge clk) ena_at_edge <= ena;

  // random clock-enable generator for the randomized phase
  always @(negedge clk) begin
    if (en_rand) ena = ($urandom_range(0, 3) != 0);
  end

  // monitor: every write must match the queue front; no write when disabled
  always @(negedge clk) begin
    logic [AW+15:0] e;
    if (rst === 1'b0) begin
      if (!ena_at_edge) check("no_write_when_disabled", vram_wr_ena, 0);
      if (vram_wr_ena === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_total++;
          n_bad++;
          $display("FAIL extra_write: got addr %0d data %h expected no write", vram_wr_addr, vram_wr_data);
        end else begin
          e = exp_q.pop_front();
          check("wr_addr", vram_wr_addr, e[AW+15:16]);
          check("wr_data", vram_wr_data, e[15:0]);
        end
        last_addr = vram_wr_addr;
        wr_count++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int k;
    k = 0;
    do begin
      step();
      k++;
    end while (!(exp_q.size() == 0 && busy === 1'b0) && k < budget);
    check(name, (exp_q.size() == 0 && busy === 1'b0), 1);
  endtask

  task automatic do_touch(input bit v, input int x, input int y,
                          input logic [15:0] color, input int lat_addr);
    bit paint;
    int bx, by, k, en_seen;
    bx = (x / 4) * 4;
    by = (y / 4) * 4;
    paint = v && (x < W) && (y < H) &&
            (!m_prev || !m_last_vld || bx != m_last_bx || by != m_last_by);
    touch.valid = v;
    touch.x     = 9'(x);
    touch.y     = 9'(y);
    brush_color = color;
    m_prev = v;
    if (paint) begin
      push_brush(bx, by, color);
      m_last_vld = 1'b1;
      m_last_bx  = bx;
      m_last_by  = by;
      if (lat_addr >= 0) begin
        step();
        check("first_brush_wr_ena", vram_wr_ena, 1);
        check("first_brush_wr_addr", vram_wr_addr, lat_addr);
      end
      wait_drain("brush_done", 300);
    end else begin
      k = 0;
      en_seen = 0;
      while (en_seen < 2 && k < 60) begin
        step();
        k++;
        if (ena_at_edge) en_seen++;
        check("idle_stays_not_busy", busy, 0);
      end
    end
  endtask

  task automatic do_clear();
    int k;
    touch.valid = 1'b0;
    m_prev = 1'b0;
    clear = 1'b1;
    push_clear();
    m_last_vld = 1'b0;
    k = 0;
    while (exp_q.size() >= VL && k < 200) begin
      step();
      k++;
    end
    check("clear_started", (exp_q.size() < VL), 1);
    clear = 1'b0;
    wait_drain("clear_done", 4 * VL + 200);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int c0, k, rx, ry, px, py;
    rst = 1'b1;
    ena = 1'b1;
    clear = 1'b0;
    touch = '0;
    brush_color = '0;
    step();
    step();
    check("rst_busy", busy, 1);
    check("rst_wr_ena", vram_wr_ena, 0);
    check("rst_wr_addr", vram_wr_addr, 0);
    check("rst_wr_data", vram_wr_data, 0);

    // power-up sweep: first write on the first enabled edge
    push_clear();
    c0 = wr_count;
    rst = 1'b0;
    step();
    check("sweep_first_wr_ena", vram_wr_ena, 1);
    check("sweep_first_wr_addr", vram_wr_addr, 0);
    wait_drain("sweep_done", VL + 50);
    check("sweep_write_count", wr_count - c0, 960);
    check("sweep_last_addr", last_addr, 959);

    // basic brush at (10,6): origin (8,4) -> 168..291 on a 40-wide display
    do_touch(1, 10, 6, 16'hF800, 168);
    check("brush_10_6_last_addr", last_addr, 291);
    // same block: nothing
    do_touch(1, 11, 7, 16'h07E0, -1);
    // new block (12,6): origin (12,4)
    do_touch(1, 12, 6, 16'h07E0, 172);
    check("brush_12_6_last_addr", last_addr, 295);
    // release and re-press on the same block repaints
    do_touch(0, 12, 6, 16'h001F, -1);
    do_touch(1, 12, 6, 16'h001F, 172);
    // off-screen touch ignored
    do_touch(1, 250, 5, 16'hFFFF, -1);
    // bottom-right corner: origin (36,20), last word of VRAM
    do_touch(1, 39, 23, 16'hABCD, 836);
    check("corner_last_addr", last_addr, 959);

    // clear and touch in the same idle cycle: clear wins, no paint
    touch.valid = 1'b1;
    touch.x = 9'd5;
    touch.y = 9'd5;
    brush_color = 16'h1234;
    clear = 1'b1;
    push_clear();
    m_last_vld = 1'b0;
    step();
    touch.valid = 1'b0;
    m_prev = 1'b0;
    k = 0;
    while (exp_q.size() >= VL && k < 50) begin
      step();
      k++;
    end
    check("clear_wins_started", (exp_q.size() < VL), 1);
    clear = 1'b0;
    wait_drain("clear_wins_done", VL + 50);

    // clear pulsed during a brush: brush completes, then the sweep
    do_touch(1, 20, 12, 16'h5A5A, 500);
    // the brush already drained; start another and pulse clear mid-brush
    touch.valid = 1'b1;
    touch.x = 9'd30;
    touch.y = 9'd2;
    brush_color = 16'hC3C3;
    push_brush(28, 0, 16'hC3C3);
    k = 0;
    while (exp_q.size() > 14 && k < 50) begin
      step();
      k++;
    end
    clear = 1'b1;
    touch.valid = 1'b0;
    step();
    clear = 1'b0;
    m_prev = 1'b0;
    push_clear();
    m_last_vld = 1'b0;
    wait_drain("pend_clear_done", VL + 100);

    // ena toggled 1,0,1,0 during a brush
    touch.x = 9'd4;
    touch.y = 9'd8;
    touch.valid = 1'b1;
    brush_color = 16'h0F0F;
    m_prev = 1'b1;
    push_brush(4, 8, 16'h0F0F);
    m_last_vld = 1'b1;
    m_last_bx = 4;
    m_last_by = 8;
    c0 = wr_count;
    k = 0;
    while (exp_q.size() != 0 && k < 80) begin
      ena = (k % 2 == 0);
      step();
      k++;
    end
    ena = 1'b1;
    wait_drain("ena_toggle_done", 50);
    check("ena_toggle_write_count", wr_count - c0, 16);

    // reset at brush write 5: sweep restarts from address 0
    touch.x = 9'd28;
    touch.y = 9'd16;
    touch.valid = 1'b0;
    step();
    touch.valid = 1'b1;
    brush_color = 16'h7777;
    push_brush(28, 16, 16'h7777);
    c0 = wr_count;
    k = 0;
    while (wr_count - c0 < 5 && k < 50) begin
      step();
      k++;
    end
    check("brush_reached_write_5", wr_count - c0, 5);
    rst = 1'b1;
    touch.valid = 1'b0;
    exp_q.delete();
    step();
    check("midbrush_rst_busy", busy, 1);
    check("midbrush_rst_wr_ena", vram_wr_ena, 0);
    m_last_vld = 1'b0;
    m_prev = 1'b0;
    push_clear();
    rst = 1'b0;
    step();
    check("restart_wr_ena", vram_wr_ena, 1);
    check("restart_wr_addr", vram_wr_addr, 0);
    wait_drain("restart_sweep_done", VL + 50);

    // randomized phase with a random clock enable
    en_rand = 1'b1;
    px = 0;
    py = 0;
    for (int i = 0; i < 70; i++) begin
      if (i == 25 || i == 55) begin
        do_clear();
      end else begin
        if ($urandom_range(0, 2) == 0) begin
          rx = px + $urandom_range(0, 2);
          ry = py + $urandom_range(0, 2);
        end else begin
          rx = $urandom_range(0, W + 4);
          ry = $urandom_range(0, H + 4);
        end
        px = rx;
        py = ry;
        do_touch(($urandom_range(0, 4) != 0), rx, ry, 16'($urandom_range(1, 65535)), -1);
      end
    end
    en_rand = 1'b0;
    step();
    ena = 1'b1;
    step();
    step();
    check("queue_empty_at_end", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/sketch_painter.md
SKETCH_PAINTER -- requirements
Module: sketch_painter

Interface
REQ-001 Parameter DISPLAY_WIDTH, default 240, sets the pixel columns.
REQ-002 Parameter DISPLAY_HEIGHT, default 320, sets the pixel rows.
REQ-003 Parameter VRAM_L, default DISPLAY_WIDTH*DISPLAY_HEIGHT, sets the VRAM depth in words.
REQ-004 Parameter CLEAR_COLOR, default 16'h0000 (BLACK), is the value written by a clear sweep.
REQ-005 Port clk, input, 1 bit: the single clock.
REQ-006 Port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-007 Port ena, input, 1 bit: clock enable; the FSM advances only when ena=1.
REQ-008 Port touch, input, touch_t: current touch event (valid, x, y).
REQ-009 Port clear, input, 1 bit: level request to clear the whole VRAM.
REQ-010 Port brush_color, input, ILI9341_color_t (16 bits): paint color, sampled at brush start.
REQ-011 Port vram_wr_ena, output, 1 bit: VRAM write strobe.
REQ-012 Port vram_wr_addr, output, $clog2(VRAM_L) bits: VRAM write address.
REQ-013 Port vram_wr_data, output, ILI9341_color_t: VRAM write data.
REQ-014 Port busy, output, 1 bit: high in any state other than S_IDLE.

Function
REQ-015 vram_wr_ena, vram_wr_addr and vram_wr_data shall be registered outputs.
REQ-016 Address mapping shall be addr = y*DISPLAY_WIDTH + x.
REQ-017 The FSM shall have exactly three states: S_CLEAR, S_IDLE and S_PAINT.
REQ-018 In S_CLEAR, with ena=1, the block shall write CLEAR_COLOR to one address per cycle, ascending from 0 to VRAM_L-1, then go to S_IDLE.
REQ-019 A clear takes exactly VRAM_L write cycles, which is 76800 at the default parameters.
REQ-020 In S_IDLE, clear=1 shall enter S_CLEAR with the sweep counter at 0; clear has priority over a simultaneous touch.
REQ-021 In S_IDLE, touch.valid=1 with x<DISPLAY_WIDTH and y<DISPLAY_HEIGHT shall enter S_PAINT, subject to REQ-025 and REQ-026.
REQ-022 On entry to S_PAINT, the block shall latch the brush origin as ({x[8:2],2'b00}, {y[8:2],2'b00}), aligned with the display cursor grid.
REQ-023 On entry to S_PAINT, the block shall latch brush_color.
REQ-024 A touch with x>=DISPLAY_WIDTH or y>=DISPLAY_HEIGHT shall be ignored, with no writes issued.
REQ-025 The block shall hold a last-block register, set to invalid by reset and by any clear.
REQ-026 A touch whose aligned block equals the last block shall not start S_PAINT.
REQ-027 A touch.valid 0->1 transition shall always paint, even when the block equals the last block.
REQ-028 S_PAINT shall write 16 pixels of the 4x4 block in row-major order, one per enabled cycle: dx 0..3 inner, dy 0..3 outer.
REQ-029 Each S_PAINT pixel shall be written with the latched color.
REQ-030 The first S_PAINT write shall occur in the cycle after the touch is sampled in S_IDLE.
REQ-031 After the 16th S_PAINT write, the FSM shall return to S_IDLE and update the last-block register.
REQ-032 A touch change during S_PAINT shall not alter the current brush.
REQ-033 A clear asserted during S_PAINT shall be latched as a pending clear.
REQ-034 A pending clear shall enter S_CLEAR immediately after the brush completes.
REQ-035 A clear asserted during S_CLEAR shall be ignored.
REQ-036 While clear remains high, S_IDLE shall re-enter S_CLEAR after each sweep completes.
REQ-037 When ena=0, vram_wr_ena shall be 0 and all state, counters and latches shall hold.
REQ-038 vram_wr_ena shall be 0 in S_IDLE.
REQ-039 The sweep address counter shall be $clog2(VRAM_L) bits wide and shall not wrap past VRAM_L-1.
REQ-040 The brush offset counters shall be 2 bits each and shall wrap 3->0.

Reset
REQ-041 When rst=1, the block shall asynchronously set state=S_CLEAR, sweep counter=0, brush counters=0, pending clear=0 and last block=invalid.
REQ-042 When rst=1, the block shall asynchronously set vram_wr_ena=0, vram_wr_addr=0, vram_wr_data=0 and busy=1.
REQ-043 A reset asserted mid-clear or mid-paint shall abort the operation, and the block shall restart the clear sweep from address 0 after rst deasserts.
REQ-044 The first write after reset deassertion shall occur on the first enabled clock edge.

Verification
REQ-045 Reset release with ena=1 -> 76800 writes of 16'h0000 to addresses 0..76799 in order, then busy=0.
REQ-046 Touch (x=10, y=6, valid) with brush_color=16'hF800 -> 16 writes to addresses 968..971, 1208..1211, 1448..1451 and 1688..1691.
REQ-047 Touch held at (10,6), then moved to (11,7) -> no further writes; moved to (12,6) -> 16 writes with origin (12,4); valid dropped then re-raised at (12,6) -> 16 writes again.
REQ-048 Touch (x=250, y=5, valid) -> no writes and busy stays 0; touch (239,319) -> block origin (236,316) with last address 76799.
REQ-049 clear and touch asserted in the same S_IDLE cycle -> clear sweep starts and the touch is not painted; clear pulsed during a brush -> 16 brush writes complete, then the sweep starts.
REQ-050 ena toggled 1,0,1,0 during a brush -> exactly 16 writes, none issued in ena=0 cycles; rst pulsed at brush write 5 -> sweep restarts at address 0.
